// File: rtl/apb3_sccb_master_pkg.sv
// apb3_sccb_pkg: register offsets, status/ctrl bit positions, SCCB constants and FSM state type.
package apb3_sccb_pkg;
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_ID     = 8'h08;
    localparam logic [7:0] OFF_SUB    = 8'h0C;
    localparam logic [7:0] OFF_WDATA  = 8'h10;
    localparam logic [7:0] OFF_CLKDIV = 8'h14;
    localparam int CTRL_START = 0;
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_NACK    = 2;
    localparam logic [15:0] CLKDIV_MIN = 16'd2;
    localparam int SCCB_BITS = 27;
    typedef enum logic [2:0] {
        IDLE, START_A, START_B, BIT_LO, BIT_HI, STOP_A, STOP_B, STOP_C
    } sccb_state_t;
    // the ninth bit of each 9-bit phase is the don't-care/ack slot
    function automatic logic is_ack_bit(input logic [4:0] b);
        return b == 5'd8 || b == 5'd17 || b == 5'd26;
    endfunction
    function automatic logic [15:0] div_eff(input logic [15:0] d);
        return d < CLKDIV_MIN ? CLKDIV_MIN : d;
    endfunction
endpackage

// File: rtl/apb3_sccb_master_if.sv
// apb3_sccb_master_if: APB3 completer bus (PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PRDATA/PREADY/PSLVERR out).
interface apb3_sccb_master_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb3_sccb_master_tx_engine.sv
// sccb_tx_engine: 3-phase SCCB write FSM; in: start, id/sub/data, clkdiv, siod_i; out: busy, done/nack pulses, sioc/siod_o/siod_oe.
module sccb_tx_engine
    import apb3_sccb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  id,
    input  logic [7:0]  sub,
    input  logic [7:0]  data,
    input  logic [15:0] clkdiv,
    input  logic        siod_i,
    output logic        busy,
    output logic        done_pulse,
    output logic        nack_pulse,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe
);
    sccb_state_t state, nxt;
    logic [15:0] cnt, div_w;
    logic [4:0] bit_cnt, bit_nxt;
    logic [SCCB_BITS-1:0] sr;
    logic adv;
    assign busy = state != IDLE;
    assign adv = state == IDLE ? start : cnt == 16'd1;
    // pulses are combinational so the shell's sticky bits set on the same edge the FSM moves
    assign done_pulse = state == STOP_C && cnt == 16'd1;
    assign nack_pulse = state == BIT_HI && cnt == div_w && is_ack_bit(bit_cnt) && siod_i;
    always_comb begin
        nxt = state;
        bit_nxt = bit_cnt;
        case (state)
            IDLE:    begin nxt = START_A; bit_nxt = '0; end
            START_A: nxt = START_B;
            START_B: nxt = BIT_LO;
            BIT_LO:  nxt = BIT_HI;
            BIT_HI:  begin
                nxt = bit_cnt == 5'(SCCB_BITS - 1) ? STOP_A : BIT_LO;
                bit_nxt = bit_cnt == 5'(SCCB_BITS - 1) ? bit_cnt : bit_cnt + 5'd1;
            end
            STOP_A:  nxt = STOP_B;
            STOP_B:  nxt = STOP_C;
            STOP_C:  nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_w   <= CLKDIV_MIN;
            bit_cnt <= '0;
            sr      <= '0;
            sioc    <= 1'b1;
            siod_o  <= 1'b1;
            siod_oe <= 1'b0;
        end else if (adv) begin
            state   <= nxt;
            bit_cnt <= bit_nxt;
            cnt     <= state == IDLE ? div_eff(clkdiv) : div_w;
            sioc    <= nxt inside {IDLE, START_A, BIT_HI, STOP_B, STOP_C};
            if (state == IDLE) begin
                div_w <= div_eff(clkdiv);
                // ack slots are loaded as 1 so they read as released
                sr    <= {id, 1'b1, sub, 1'b1, data, 1'b1};
            end
            if (nxt == BIT_LO) begin
                siod_o  <= sr[SCCB_BITS-1];
                siod_oe <= !is_ack_bit(bit_nxt);
                sr      <= sr << 1;
            end else if (nxt != BIT_HI) begin
                siod_o  <= !(nxt inside {START_A, START_B, STOP_A, STOP_B});
                siod_oe <= nxt inside {START_A, START_B, STOP_A, STOP_B};
            end
        end else if (busy) begin
            cnt <= cnt - 16'd1;
        end
    end
endmodule

// File: rtl/apb3_sccb_master.sv
// apb3_sccb_master: APB3 register shell (CTRL/STATUS/ID/SUBADDR/WDATA/CLKDIV) around sccb_tx_engine; ports PCLK/PRESET, apb slave, SIOC/SIOD_O/SIOD_OE/SIOD_I.
module apb3_sccb_master
    import apb3_sccb_pkg::*;
#(
    parameter int          APB_DWIDTH    = 32,
    parameter int          ADDR_LSB_BITS = 8,
    parameter logic [15:0] CLKDIV_RESET  = 16'd250
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb3_sccb_master_if.slave   apb,
    output logic                SIOC,
    output logic                SIOD_O,
    output logic                SIOD_OE,
    input  logic                SIOD_I
);
    logic [ADDR_LSB_BITS-1:0] off;
    logic [7:0] id, sub, wdat;
    logic [15:0] clkdiv;
    logic done, nack, busy, done_p, nack_p;
    logic wr, w1c, cfg_wr, start_acc, locked, mapped;
    logic [APB_DWIDTH-1:0] rdata;
    logic unused_bits;
    assign unused_bits = ^{apb.PADDR[31:ADDR_LSB_BITS], apb.PWDATA[31:16]};
    assign off = apb.PADDR[ADDR_LSB_BITS-1:0];
    assign mapped = off inside {OFF_CTRL, OFF_STATUS, OFF_ID, OFF_SUB, OFF_WDATA, OFF_CLKDIV};
    assign wr = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign w1c = wr & off == OFF_STATUS;
    assign cfg_wr = wr & !busy;
    assign start_acc = cfg_wr & off == OFF_CTRL & apb.PWDATA[CTRL_START];
    // a CTRL write with START=0 is harmless while busy; config writes are not
    assign locked = busy & (off == OFF_CTRL ? apb.PWDATA[CTRL_START]
                          : off inside {OFF_ID, OFF_SUB, OFF_WDATA, OFF_CLKDIV});
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & (!mapped | (apb.PWRITE & locked));
    assign apb.PREADY = 1'b1;
    assign rdata = !apb.PSEL ? '0
                 : off == OFF_STATUS ? APB_DWIDTH'({nack, done, busy})
                 : off == OFF_ID     ? APB_DWIDTH'(id)
                 : off == OFF_SUB    ? APB_DWIDTH'(sub)
                 : off == OFF_WDATA  ? APB_DWIDTH'(wdat)
                 : off == OFF_CLKDIV ? APB_DWIDTH'(clkdiv)
                 : '0;
    assign apb.PRDATA = rdata;
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            id     <= '0;
            sub    <= '0;
            wdat   <= '0;
            clkdiv <= CLKDIV_RESET;
            done   <= 1'b0;
            nack   <= 1'b0;
        end else begin
            if (cfg_wr & off == OFF_ID)     id     <= apb.PWDATA[7:0];
            if (cfg_wr & off == OFF_SUB)    sub    <= apb.PWDATA[7:0];
            if (cfg_wr & off == OFF_WDATA)  wdat   <= apb.PWDATA[7:0];
            if (cfg_wr & off == OFF_CLKDIV) clkdiv <= apb.PWDATA[15:0];
            // hardware set outranks both START clear and W1C
            done <= done_p | (done & !start_acc & !(w1c & apb.PWDATA[ST_DONE]));
            nack <= nack_p | (nack & !start_acc & !(w1c & apb.PWDATA[ST_NACK]));
        end
    end
    sccb_tx_engine u_eng (
        .clk        (PCLK),
        .rst        (PRESET),
        .start      (start_acc),
        .id         (id),
        .sub        (sub),
        .data       (wdat),
        .clkdiv     (clkdiv),
        .siod_i     (SIOD_I),
        .busy       (busy),
        .done_pulse (done_p),
        .nack_pulse (nack_p),
        .sioc       (SIOC),
        .siod_o     (SIOD_O),
        .siod_oe    (SIOD_OE)
    );
endmodule

// File: tb/tb_apb3_sccb_master.sv
// tb_apb3_sccb_master: randomized self-checking bench for apb3_sccb_master against a transaction-level model.
module tb_apb3_sccb_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sioc, siod_o, siod_oe;
    logic siod_i = 1'b1;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int oe_rises = 0;
    int base = 0;
    logic [2:0] pat = '0;
    logic sioc_q = 1'b1;
    logic oe_q = 1'b0;
    logic cap_d[$];
    logic cap_oe[$];

    apb3_sccb_master_if apb();

    apb3_sccb_master dut (
        .PCLK    (clk),
        .PRESET  (rst),
        .apb     (apb),
        .SIOC    (sioc),
        .SIOD_O  (siod_o),
        .SIOD_OE (siod_oe),
        .SIOD_I  (siod_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // bus monitor plus a slave that answers each ack slot with the chosen pattern bit
    always @(negedge clk) begin
        int idx;
        if (sioc && !sioc_q) begin
            cap_d.push_back(siod_oe ? siod_o : siod_i);
            cap_oe.push_back(siod_oe);
        end
        sioc_q = sioc;
        if (siod_oe && !oe_q) oe_rises++;
        oe_q = siod_oe;
        idx = oe_rises - base - 1;
        siod_i = (idx >= 0 && idx < 3) ? pat[idx] : 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        @(posedge clk); #1;
        apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 1; apb.PADDR = {24'h0, a}; apb.PWDATA = d;
        @(posedge clk); #1;
        apb.PENABLE = 1;
        @(negedge clk);
        err = apb.PSLVERR;
        @(posedge clk); #1;
        apb.PSEL = 0; apb.PENABLE = 0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        @(posedge clk); #1;
        apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = {24'h0, a};
        @(posedge clk); #1;
        apb.PENABLE = 1;
        @(negedge clk);
        d = apb.PRDATA;
        err = apb.PSLVERR;
        chk("pready", {31'h0, apb.PREADY}, 32'h1);
        @(posedge clk); #1;
        apb.PSEL = 0; apb.PENABLE = 0;
    endtask

    task automatic configure(input logic [15:0] div, input logic [7:0] a, b, c);
        logic e;
        apb_write(8'h14, {16'h0, div}, e); chk("cfg_err", {31'h0, e}, 0);
        apb_write(8'h08, {24'h0, a}, e);
        apb_write(8'h0C, {24'h0, b}, e);
        apb_write(8'h10, {24'h0, c}, e);
    endtask

    // op: 0 none, 1 START while busy, 2 WDATA write while busy, 3 unmapped read while busy
    task automatic run_xfer(input logic [15:0] div, input logic [7:0] a, b, c, input logic [2:0] p, input int op);
        logic e;
        logic [31:0] r;
        logic [27:0] gd, go;
        int c0, half;
        configure(div, a, b, c);
        pat = p;
        cap_d.delete();
        cap_oe.delete();
        base = oe_rises;
        apb_write(8'h00, 32'h1, e);
        c0 = cyc;
        chk("start_err", {31'h0, e}, 0);
        if (op == 1) begin apb_write(8'h00, 32'h1, e); chk("start_busy_err", {31'h0, e}, 1); end
        if (op == 2) begin apb_write(8'h10, {24'h0, ~c}, e); chk("wdata_busy_err", {31'h0, e}, 1); end
        if (op == 3) begin
            apb_read(8'h20, r, e);
            chk("unmapped_err", {31'h0, e}, 1);
            chk("unmapped_rd", r, 0);
        end
        apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 32'h4;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!apb.PRDATA[0]) break;
        end
        half = div < 2 ? 2 : int'(div);
        chk("busy_len", cyc - c0, 59 * half);
        chk("status_end", apb.PRDATA, {29'h0, |p, 2'b10});
        @(posedge clk); #1;
        apb.PSEL = 0;
        gd = '0; go = '0;
        foreach (cap_d[i]) begin
            gd = {gd[26:0], cap_d[i]};
            go = {go[26:0], cap_oe[i]};
        end
        chk("cap_cnt", cap_d.size(), 28);
        chk("siod_bits", {4'h0, gd}, {4'h0, a, p[0], b, p[1], c, p[2], 1'b0});
        chk("oe_bits", {4'h0, go}, {4'h0, 8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1});
        if (op == 2) begin apb_read(8'h10, r, e); chk("wdata_kept", r, {24'h0, c}); end
    endtask

    initial begin
        logic [31:0] r;
        logic e;
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 0; apb.PWDATA = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sioc", {31'h0, sioc}, 1);
        chk("rst_oe", {31'h0, siod_oe}, 0);
        chk("rst_prdata", apb.PRDATA, 0);
        chk("rst_pslverr", {31'h0, apb.PSLVERR}, 0);
        rst = 0;
        apb_read(8'h04, r, e); chk("rst_status", r, 0);
        apb_read(8'h14, r, e); chk("rst_clkdiv", r, 32'hFA);
        chk("idle_sioc", {31'h0, sioc}, 1);
        chk("idle_oe", {31'h0, siod_oe}, 0);
        apb_read(8'h20, r, e);
        chk("unmapped_err", {31'h0, e}, 1);
        chk("unmapped_rd", r, 0);
        run_xfer(16'd4, 8'h42, 8'h12, 8'h80, 3'b000, 0);
        run_xfer(16'd3, 8'h42, 8'h12, 8'h80, 3'b111, 0);
        apb_write(8'h04, 32'h6, e);
        apb_read(8'h04, r, e); chk("w1c_clear", r, 0);
        run_xfer(16'd0, 8'hA5, 8'h3C, 8'h5A, 3'b010, 1);
        run_xfer(16'd2, 8'h11, 8'h22, 8'h33, 3'b001, 2);
        for (int k = 0; k < 6; k++)
            run_xfer(16'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), 8'($urandom),
                     3'($urandom), int'($urandom_range(0, 3)));
        configure(16'd3, 8'hC3, 8'h96, 8'h69);
        apb_write(8'h00, 32'h1, e);
        repeat (70) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("mid_rst_sioc", {31'h0, sioc}, 1);
        chk("mid_rst_oe", {31'h0, siod_oe}, 0);
        apb_read(8'h04, r, e); chk("mid_rst_status", r, 0);
        apb_read(8'h08, r, e); chk("mid_rst_id", r, 0);
        apb_read(8'h14, r, e); chk("mid_rst_clkdiv", r, 32'hFA);
        run_xfer(16'd2, 8'h78, 8'h0F, 8'hE1, 3'b100, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb3_sccb_master.md
Name: apb3_sccb_master

Overview:
APB3 completer (slave) that occupies one CoreAPB3 slot and gives the soft-core CPU control of the camera SCCB port. Firmware programs the device ID, sub-address, write data and clock divider, then sets START. The block then performs a 3-phase SCCB write (ID, sub-address, data) on SIOC/SIOD and reports BUSY, DONE and NACK through a status register.

Parameters:
APB_DWIDTH, 32, APB data width; only 32 is supported.
ADDR_LSB_BITS, 8, number of PADDR bits decoded; upper bits are ignored because the interconnect has already selected this slot.
CLKDIV_RESET, 16'd250, reset value of CLKDIV, giving 100 kHz at a 50 MHz PCLK.

Ports:
PCLK  in  1  system clock.
PRESET  in  1  synchronous reset, active-high.
PSEL  in  1  APB select from the interconnect.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  32  byte address; bits [7:0] are decoded.
PWDATA  in  32  write data.
PRDATA  out  32  read data.
PREADY  out  1  tied to 1; zero wait states.
PSLVERR  out  1  error response.
SIOC  out  1  SCCB clock.
SIOD_O  out  1  SCCB data output value.
SIOD_OE  out  1  1 = drive SIOD; 0 = release SIOD to the pull-up.
SIOD_I  in  1  SCCB data input, already synchronised by the top level.

Behaviour:
- Reset values, taking effect on the first PCLK edge with PRESET=1, including mid-transaction:
  - SIOC=1, SIOD_O=1, SIOD_OE=0, PRDATA=0, PSLVERR=0.
  - ID=0, SUBADDR=0, WDATA=0, CLKDIV=CLKDIV_RESET, STATUS=0.
  - FSM returns to IDLE.
- APB access:
  - A write is PSEL&PENABLE&PWRITE; a read is PSEL&PENABLE&!PWRITE.
  - PRDATA is combinational from PADDR while PSEL=1, and 0 otherwise.
  - Unused register bits read as 0.
- Register map:
  - 0x00 CTRL: bit0 START, write-1-to-trigger, reads 0.
  - 0x04 STATUS: bit0 BUSY (read-only); bit1 DONE (sticky, write-1-to-clear); bit2 NACK (sticky, write-1-to-clear).
  - 0x08 ID [7:0].
  - 0x0C SUBADDR [7:0].
  - 0x10 WDATA [7:0].
  - 0x14 CLKDIV [15:0]: SIOC half-period in PCLK cycles; values below 2 are used as 2.
- PSLVERR=1 during the access phase for:
  - any access to an unmapped offset; reads return 0 and writes are ignored;
  - a START write while BUSY=1;
  - a write to ID, SUBADDR, WDATA or CLKDIV while BUSY=1; the write is ignored.
- START accepted (BUSY=0):
  - The 27-bit shift register loads {ID,X, SUBADDR,X, WDATA,X}.
  - CLKDIV is latched into a working copy.
  - DONE and NACK clear.
  - BUSY=1 from the next cycle.
- FSM states, each lasting exactly CLKDIV_eff PCLK cycles (one half-period):
  - IDLE: SIOC=1, SIOD_OE=0.
  - START_A: SIOC=1, SIOD driven 0.
  - START_B: SIOC=0, SIOD driven 0.
  - BIT_LO: SIOC=0; SIOD updated on the first cycle of the state. Bits 0-7 of each phase drive MSB-first. Bit 8 (X) sets OE=0.
  - BIT_HI: SIOC=1. For bit 8, SIOD_I is sampled on the first BIT_HI cycle; a 1 sets NACK. The transfer does not abort on NACK.
  - The BIT_LO/BIT_HI pair repeats 27 times.
  - STOP_A: SIOC=0, SIOD driven 0.
  - STOP_B: SIOC=1, SIOD driven 0.
  - STOP_C: SIOC=1, OE=0.
  - At the end of STOP_C: BUSY=0 and DONE=1 in the same cycle, then IDLE.
- Transaction length: 59 half-periods, so BUSY is high for 59*CLKDIV_eff cycles.
- Simultaneous events:
  - Hardware DONE/NACK set and a W1C in the same cycle: set wins.
  - A START write in the cycle that BUSY falls is rejected, because BUSY is still 1 in that cycle.
- Counters:
  - 16-bit half-period down-counter; it reloads at each state change and never wraps through 0.
  - 5-bit bit counter, 0..26.

Decomposition:
- Package apb3_sccb_pkg contains:
  - register offsets;
  - STATUS/CTRL bit positions;
  - CLKDIV_MIN=2;
  - SCCB_BITS=27;
  - the FSM state enum.
- Sub-module sccb_tx_engine holds the FSM, the counters and the shift register.
  - Inputs: start, id/sub/data, clkdiv.
  - Outputs: busy, done_pulse, nack_pulse, SIOC/SIOD_O/SIOD_OE.
- apb3_sccb_master is the APB register shell around it.

Test Plan:
- Reset and defaults: assert PRESET, then read 0x04 -> 0, 0x14 -> 0x000000FA; PREADY=1 and SIOC=1, SIOD_OE=0 throughout.
- Basic write: CLKDIV=4, ID=0x42, SUBADDR=0x12, WDATA=0x80, START -> SIOD captured on SIOC rising edges = 0100_0010 X 0001_0010 X 1000_0000 X; BUSY high exactly 236 cycles; then STATUS=0x2.
- NACK sampling: SIOD_I=1 during all X bits -> STATUS=0x6 at completion; write 0x6 to 0x04 -> read 0.
- Errors: START while BUSY -> PSLVERR=1 and the transfer is undisturbed; a write to 0x10 while BUSY -> PSLVERR=1 and WDATA unchanged; a read of 0x20 -> PSLVERR=1, PRDATA=0.
- CLKDIV clamp: CLKDIV=0 -> half-period of 2 cycles, BUSY high 118 cycles.
- Reset mid-operation: PRESET during phase 2 -> the next cycle shows SIOC=1, SIOD_OE=0, STATUS=0; a fresh START then completes normally.
